sevenseg_scan_ctrl: RTL and testbench

//  Time-multiplexing scan controller for an N-digit common-anode 7-seg display.

---
 rtl/sevenseg_scan_ctrl.sv | 119 +++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexing scan controller for an N-digit common-anode 7-segment display.
// Double-buffered digit codes: staging is promoted to active only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int ON_CYCLES    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [7*N_DIGITS-1:0]         d_in,
  output logic [6:0]                    d_out,
  output logic [N_DIGITS-1:0]           an_n,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
  output logic                          frame_done,
  output logic                          pending
);

  localparam int IW      = $clog2(N_DIGITS);
  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0]       ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0]       LAST_IDX   = IW'(N_DIGITS - 1);
  localparam logic [6:0]          BLANK_CODE = 7'h40;
  localparam logic [N_DIGITS-1:0] ONE_HOT0   = N_DIGITS'(1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [6:0]    staging [N_DIGITS];
  logic [6:0]    active  [N_DIGITS];

  logic [IW-1:0] next_idx;
  logic          wrap;
  logic          commit;

  // A frame boundary is either the end of the last digit or the start of scanning from idle.
  always_comb begin
    next_idx = (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
    wrap     = (state == ON) && (cnt == ON_LAST) && (digit_idx == LAST_IDX);
    commit   = pending && en && (wrap || (state == IDLE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      digit_idx  <= '0;
      an_n       <= '1;
      d_out      <= BLANK_CODE;
      frame_done <= 1'b0;
      pending    <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        staging[i] <= BLANK_CODE;
        active[i]  <= BLANK_CODE;
      end
    end else begin
      frame_done <= 1'b0;

      // A load on the commit edge lands in staging after the old contents move to active.
      if (commit) begin
        active  <= staging;
        pending <= 1'b0;
      end
      if (load) begin
        for (int i = 0; i < N_DIGITS; i++)
          staging[i] <= d_in[7*i +: 7];
        pending <= 1'b1;
      end

      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        digit_idx <= '0;
        an_n      <= '1;
        d_out     <= BLANK_CODE;
      end else begin
        case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            an_n  <= '1;
            d_out <= commit ? staging[0] : active[0];
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              state <= ON;
              cnt   <= '0;
              an_n  <= ~(ONE_HOT0 << digit_idx);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ON: begin
            if (cnt == ON_LAST) begin
              state      <= BLANK;
              cnt        <= '0;
              an_n       <= '1;
              digit_idx  <= next_idx;
              d_out      <= commit ? staging[next_idx] : active[next_idx];
              frame_done <= wrap;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            an_n  <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with N_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2.
// Each digit slot is 6 cycles (2 blank + 4 on); a frame is 24 cycles.
module tb_sevenseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [27:0] d_in;
  logic [6:0]  d_out;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        pending;

  int         vectors;
  int         miscompares;
  int         pos;
  logic [6:0] exp_codes [4];
  logic       exp_pending;

  sevenseg_scan_ctrl #(
    .N_DIGITS    (4),
    .ON_CYCLES   (4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .d_in      (d_in),
    .d_out     (d_out),
    .an_n      (an_n),
    .digit_idx (digit_idx),
    .frame_done(frame_done),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s at pos %0d: observed %h expected %h", tag, pos, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_codes(input logic [6:0] c3, input logic [6:0] c2,
                           input logic [6:0] c1, input logic [6:0] c0);
    exp_codes[0] = c0;
    exp_codes[1] = c1;
    exp_codes[2] = c2;
    exp_codes[3] = c3;
  endtask

  // pos counts cycles since the edge that left IDLE; slot r<2 is dead-time, r>=2 is the lit digit.
  task automatic check_scan();
    int digit;
    int r;
    logic [3:0] exp_an;
    digit  = (pos / 6) % 4;
    r      = pos % 6;
    exp_an = (r < 2) ? 4'hF : ~(4'b0001 << digit);
    check_output("an_n", 32'(an_n), 32'(exp_an));
    check_output("d_out", 32'(d_out), 32'(exp_codes[digit]));
    check_output("digit_idx", 32'(digit_idx), 32'(digit));
    check_output("frame_done", 32'(frame_done), 32'((pos > 0) && (pos % 24 == 0)));
    check_output("pending", 32'(pending), 32'(exp_pending));
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      check_scan();
      tick();
      pos++;
    end
  endtask

  task automatic check_idle(input string tag, input logic exp_pend);
    check_output({tag, "_an_n"}, 32'(an_n), 32'h0000000F);
    check_output({tag, "_d_out"}, 32'(d_out), 32'h00000040);
    check_output({tag, "_idx"}, 32'(digit_idx), 32'h0);
    check_output({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    check_output({tag, "_pending"}, 32'(pending), 32'(exp_pend));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pos         = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    load        = 1'b0;
    d_in        = '0;
    exp_pending = 1'b0;
    set_codes(7'h03, 7'h02, 7'h01, 7'h00);

    // Reset state
    tick();
    tick();
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset", 1'b0);

    // Load while idle, then start scanning: staged codes are shown from the first frame
    load = 1'b1;
    d_in = {7'h03, 7'h02, 7'h01, 7'h00};
    tick();
    load = 1'b0;
    check_idle("idle_load", 1'b1);
    en = 1'b1;
    tick();
    pos = 0;
    exp_pending = 1'b0;
    apply_stimulus(80);

    // Mid-frame load during digit 1 ON: no visible change until the wrap
    load = 1'b1;
    d_in = {4{7'h55}};
    apply_stimulus(1);
    load = 1'b0;
    exp_pending = 1'b1;
    apply_stimulus(15);
    set_codes(7'h55, 7'h55, 7'h55, 7'h55);
    exp_pending = 1'b0;
    apply_stimulus(15);

    // Drop en during ON of digit 2
    en = 1'b0;
    tick();
    check_idle("en_drop", 1'b0);
    tick();
    check_idle("en_idle", 1'b0);
    en = 1'b1;
    tick();
    pos = 0;
    apply_stimulus(30);

    // Load A mid-frame, then load B on the wrap edge
    load = 1'b1;
    d_in = {7'h13, 7'h12, 7'h11, 7'h10};
    apply_stimulus(1);
    load = 1'b0;
    exp_pending = 1'b1;
    apply_stimulus(16);
    load = 1'b1;
    d_in = {7'h2D, 7'h2C, 7'h2B, 7'h2A};
    apply_stimulus(1);
    load = 1'b0;
    set_codes(7'h13, 7'h12, 7'h11, 7'h10);
    apply_stimulus(24);
    set_codes(7'h2D, 7'h2C, 7'h2B, 7'h2A);
    exp_pending = 1'b0;
    apply_stimulus(8);

    // Async reset mid-ON with data pending
    load = 1'b1;
    d_in = {4{7'h0F}};
    apply_stimulus(1);
    load = 1'b0;
    exp_pending = 1'b1;
    apply_stimulus(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset", 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    pos = 0;
    exp_pending = 1'b0;
    set_codes(7'h40, 7'h40, 7'h40, 7'h40);
    apply_stimulus(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
